// File: rtl/dpd_layer_pkg.sv
// Shared types and helpers for the quantised layer sequencer.
`default_nettype none

package dpd_layer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    ISSUE = 3'd2,
    DRAIN = 3'd3,
    WB    = 3'd4,
    DONE  = 3'd5
  } seq_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Round half up at the shift point, then clamp to a signed w-bit range.
  function automatic logic signed [63:0] sat_round(input logic signed [63:0] r,
                                                   input int shift, input int w);
    logic signed [63:0] q;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    q  = (shift > 0) ? ((r + (64'sd1 <<< (shift - 1))) >>> shift) : r;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (q > hi)      q = hi;
    else if (q < lo) q = lo;
    return q;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sparse_layer_sequencer_lowest_set_bit.sv
// Priority encoder: index of the lowest set bit of a mask, plus an any-set flag.
`default_nettype none

module lowest_set_bit #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = IW'(i);
        o_any = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/sparse_layer_sequencer.sv
// Runs one shared PAR-lane MAC over the nonzero weight chunks of every neuron in a layer,
// then adds bias, requantises, saturates, optionally applies ReLU and writes the result.
`default_nettype none

module sparse_layer_sequencer
  import dpd_layer_pkg::*;
#(
  parameter int N_IN  = 12,
  parameter int N_OUT = 12,
  parameter int PAR   = 3,
  parameter int W     = 14,
  parameter int ACC_W = 32,
  parameter int SHIFT = 11,
  parameter int RELU  = 1,
  localparam int CHUNKS = ceil_div(N_IN, PAR),
  localparam int NW     = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  output logic              o_busy,
  output logic              o_done,
  output logic [NW-1:0]     o_nz_idx,
  input  logic [CHUNKS-1:0] i_nz_mask,
  output logic              o_rd_en,
  output logic [NW-1:0]     o_rd_neuron,
  output logic [CW-1:0]     o_rd_chunk,
  input  logic [PAR*W-1:0]  i_wgt_lanes,
  input  logic [PAR*W-1:0]  i_act_lanes,
  input  logic [W-1:0]      i_bias,
  output logic              o_wr_en,
  output logic [NW-1:0]     o_wr_addr,
  output logic [W-1:0]      o_wr_data
);

  localparam int PW = 2 * W;

  seq_state_e               r_state;
  logic [NW-1:0]            r_n;
  logic [CHUNKS-1:0]        r_pending;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_wr_en;
  logic [NW-1:0]            r_wr_addr;
  logic [W-1:0]             r_wr_data;
  logic                     r_v;
  logic                     r_first;
  logic                     r_bias_only;
  logic [CW-1:0]            r_chunk_q;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [W-1:0]      r_bias;

  logic                     w_scan;
  logic                     w_issue;
  logic [CHUNKS-1:0]        w_src;
  logic [CHUNKS-1:0]        w_clear;
  logic [CHUNKS-1:0]        w_pend_after;
  logic [CW-1:0]            w_low;
  logic                     w_any;
  logic signed [PW-1:0]     w_prod [PAR];
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [ACC_W-1:0]  w_acc_next;
  logic signed [W-1:0]      w_bias_eff;
  logic signed [63:0]       w_r;
  logic signed [63:0]       w_q;
  logic [W-1:0]             w_result;

  assign w_scan  = (r_state == SCAN);
  assign w_issue = (r_state == ISSUE);

  // The mask is only looked at during SCAN; afterwards the latched copy drives the issue order.
  assign w_src        = w_scan ? i_nz_mask : r_pending;
  assign w_clear      = w_any ? (CHUNKS'(1) << w_low) : '0;
  assign w_pend_after = w_src & ~w_clear;

  lowest_set_bit #(
    .N  (CHUNKS),
    .IW (CW)
  ) u_lsb (
    .i_vec (w_src),
    .o_idx (w_low),
    .o_any (w_any)
  );

  // SCAN issues the first read itself (chunk 0 as a bias-only read for an all-zero mask).
  assign o_rd_en     = w_scan | w_issue;
  assign o_rd_chunk  = (o_rd_en && w_any) ? w_low : '0;
  assign o_rd_neuron = r_n;
  assign o_nz_idx    = r_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_n       <= '0;
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_state <= SCAN;
            r_n     <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCAN, ISSUE: begin
          r_pending <= w_pend_after;
          r_state   <= (w_pend_after != '0) ? ISSUE : DRAIN;
        end
        DRAIN: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_n;
          r_wr_data <= w_result;
          r_state   <= WB;
        end
        WB: begin
          r_wr_en <= 1'b0;
          if (r_n == NW'(N_OUT - 1)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_n     <= r_n + NW'(1);
            r_state <= SCAN;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    for (int l = 0; l < PAR; l++) begin
      w_prod[l] = PW'($signed(i_wgt_lanes[l*W +: W])) * PW'($signed(i_act_lanes[l*W +: W]));
    end
  end

  // Lanes past N_IN in the last chunk, and every lane of a bias-only read, contribute nothing.
  always_comb begin
    w_sum = '0;
    for (int l = 0; l < PAR; l++) begin
      if (!r_bias_only && ((int'(r_chunk_q) * PAR + l) < N_IN)) begin
        w_sum = w_sum + ACC_W'(w_prod[l]);
      end
    end
  end

  assign w_acc_next = (r_first ? '0 : r_acc) + w_sum;
  assign w_bias_eff = r_first ? $signed(i_bias) : r_bias;

  always_comb begin
    w_r = 64'(w_acc_next) + (64'(w_bias_eff) <<< SHIFT);
    w_q = sat_round(w_r, SHIFT, W);
    if (RELU != 0 && w_q < 0) begin
      w_q = '0;
    end
  end

  assign w_result = W'(w_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v         <= 1'b0;
      r_first     <= 1'b0;
      r_bias_only <= 1'b0;
      r_chunk_q   <= '0;
      r_acc       <= '0;
      r_bias      <= '0;
    end else begin
      r_v         <= o_rd_en;
      r_first     <= w_scan;
      r_bias_only <= w_scan & ~w_any;
      r_chunk_q   <= o_rd_chunk;
      if (r_v) begin
        r_acc <= w_acc_next;
        if (r_first) begin
          r_bias <= i_bias;
        end
      end
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_wr_en   = r_wr_en;
  assign o_wr_addr = r_wr_addr;
  assign o_wr_data = r_wr_data;

endmodule

`default_nettype wire

// File: tb/tb_sparse_layer_sequencer.sv
// Three sequencer configurations run in lockstep against a shared memory model and a layer-level reference.
`default_nettype none

module tb_sparse_layer_sequencer;

  localparam int N_OUT  = 12;
  localparam int PAR    = 3;
  localparam int W      = 14;
  localparam int CHUNKS = 4;
  localparam int NW     = 4;
  localparam int CW     = 2;
  localparam int NI_MAX = 12;
  localparam int NDUT   = 3;
  localparam int CFG_NIN   [NDUT] = '{12, 11, 12};
  localparam int CFG_SHIFT [NDUT] = '{0, 11, 11};
  localparam int CFG_RELU  [NDUT] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [PAR*W-1:0] wgt_lanes;
  logic [PAR*W-1:0] act_lanes;
  logic [W-1:0]     bias;

  logic          busy      [NDUT];
  logic          done      [NDUT];
  logic          rd_en     [NDUT];
  logic          wr_en     [NDUT];
  logic [NW-1:0] nz_idx    [NDUT];
  logic [NW-1:0] rd_neuron [NDUT];
  logic [NW-1:0] wr_addr   [NDUT];
  logic [CW-1:0] rd_chunk  [NDUT];
  logic [W-1:0]  wr_data   [NDUT];

  logic signed [W-1:0] wm [N_OUT][NI_MAX];
  logic signed [W-1:0] am [NI_MAX];
  logic signed [W-1:0] bm [N_OUT];
  logic [CHUNKS-1:0]   maskm [N_OUT];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int S = 0;
  bit active = 1'b0;
  int rdq[$];
  int exp_val [NDUT][N_OUT];
  int exp_cyc [N_OUT];
  int wr_idx  [NDUT];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    logic [CHUNKS-1:0] mask_g;
    assign mask_g = maskm[nz_idx[g]];
    sparse_layer_sequencer #(
      .N_IN  (g == 1 ? 11 : 12),
      .N_OUT (N_OUT),
      .PAR   (PAR),
      .W     (W),
      .ACC_W (32),
      .SHIFT (g == 0 ? 0 : 11),
      .RELU  (g == 1 ? 1 : 0)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_start     (start),
      .o_busy      (busy[g]),
      .o_done      (done[g]),
      .o_nz_idx    (nz_idx[g]),
      .i_nz_mask   (mask_g),
      .o_rd_en     (rd_en[g]),
      .o_rd_neuron (rd_neuron[g]),
      .o_rd_chunk  (rd_chunk[g]),
      .i_wgt_lanes (wgt_lanes),
      .i_act_lanes (act_lanes),
      .i_bias      (bias),
      .o_wr_en     (wr_en[g]),
      .o_wr_addr   (wr_addr[g]),
      .o_wr_data   (wr_data[g])
    );
  end

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  // Reference: dot product over the chunks the mask keeps, plus scaled bias, rounded, clamped.
  function automatic int model(input int g, input int n);
    longint acc, r, d, q, hi, lo;
    int i;
    acc = 0;
    for (int c = 0; c < CHUNKS; c++) begin
      if (maskm[n][c]) begin
        for (int l = 0; l < PAR; l++) begin
          i = c * PAR + l;
          if (i < CFG_NIN[g]) acc += longint'(wm[n][i]) * longint'(am[i]);
        end
      end
    end
    d  = longint'(1) << CFG_SHIFT[g];
    r  = acc + longint'(bm[n]) * d;
    q  = floor_div(r + d / 2, d);
    hi = (longint'(1) << (W - 1)) - 1;
    lo = -(longint'(1) << (W - 1));
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    if (CFG_RELU[g] != 0 && q < 0) q = 0;
    return int'(q);
  endfunction

  // Memory model: data for a read seen in one cycle is presented during the next.
  initial begin
    logic          cap_en;
    logic [NW-1:0] cap_n;
    logic [CW-1:0] cap_c;
    int            idx;
    wgt_lanes = '0;
    act_lanes = '0;
    bias      = '0;
    forever begin
      @(negedge clk);
      cap_en = rd_en[0];
      cap_n  = rd_neuron[0];
      cap_c  = rd_chunk[0];
      @(posedge clk);
      #1;
      for (int l = 0; l < PAR; l++) begin
        idx = int'(cap_c) * PAR + l;
        if (cap_en && idx < NI_MAX) begin
          wgt_lanes[l*W +: W] = wm[cap_n][idx];
          act_lanes[l*W +: W] = am[idx];
        end else begin
          wgt_lanes[l*W +: W] = W'($urandom());
          act_lanes[l*W +: W] = W'($urandom());
        end
      end
      bias = cap_en ? bm[cap_n] : W'($urandom());
    end
  end

  always @(negedge clk) begin
    int e;
    if (!rst) begin
      if (rd_en[0]) begin
        if (!active || rdq.size() == 0) begin
          check_val("rd_unexpected", rd_en[0], 0);
        end else begin
          e = rdq.pop_front();
          check_val("rd_neuron", rd_neuron[0], e / 16);
          check_val("rd_chunk", rd_chunk[0], e % 16);
        end
      end
      for (int g = 0; g < NDUT; g++) begin
        if (wr_en[g]) begin
          if (!active || wr_idx[g] >= N_OUT) begin
            check_val("wr_unexpected", wr_en[g], 0);
          end else begin
            check_val("wr_addr", wr_addr[g], wr_idx[g]);
            check_val("wr_data", $signed(wr_data[g]), exp_val[g][wr_idx[g]]);
            check_val("wr_cycle", cyc, S + exp_cyc[wr_idx[g]]);
            wr_idx[g]++;
          end
        end
      end
    end
  end

  task automatic run_pass(input int abort_at);
    int pop, tot, timeout;
    rdq.delete();
    tot = 0;
    for (int n = 0; n < N_OUT; n++) begin
      pop = $countones(maskm[n]);
      for (int c = 0; c < CHUNKS; c++) if (maskm[n][c]) rdq.push_back(n * 16 + c);
      if (pop == 0) rdq.push_back(n * 16);
      tot += ((pop == 0) ? 1 : pop) + 2;
      exp_cyc[n] = tot - 1;
      for (int g = 0; g < NDUT; g++) exp_val[g][n] = model(g, n);
    end
    for (int g = 0; g < NDUT; g++) wr_idx[g] = 0;
    active = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    S = cyc;
    @(negedge clk);
    check_val("busy_high", busy[0], 1);
    timeout = 0;
    if (abort_at < 0) begin
      while (!done[0] && timeout < 500) begin
        @(negedge clk);
        timeout++;
      end
      if (!done[0]) begin
        check_val("done_timeout", done[0], 1);
      end else begin
        check_val("done_cycle", cyc, S + tot);
        for (int g = 0; g < NDUT; g++) begin
          check_val("done_all", done[g], 1);
          check_val("wr_count", wr_idx[g], N_OUT);
        end
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) begin
          check_val("done_pulse", done[g], 0);
          check_val("busy_idle", busy[g], 0);
        end
      end
      active = 1'b0;
    end else begin
      while (!(rd_en[0] && rd_neuron[0] == NW'(abort_at) && rd_chunk[0] == CW'(1))
             && timeout < 500) begin
        @(negedge clk);
        timeout++;
      end
      check_val("abort_reached", timeout < 500, 1);
      rst = 1'b1;
      active = 1'b0;
      rdq.delete();
      @(negedge clk);
      for (int g = 0; g < NDUT; g++) begin
        check_val("abort_busy", busy[g], 0);
        check_val("abort_wr_en", wr_en[g], 0);
        check_val("abort_done", done[g], 0);
      end
      rst = 1'b0;
      repeat (4) @(negedge clk);
      check_val("abort_idle_rd", rd_en[0], 0);
    end
  endtask

  task automatic randomize_layer();
    for (int n = 0; n < N_OUT; n++) begin
      maskm[n] = CHUNKS'($urandom_range(0, 15));
      bm[n]    = W'($urandom());
      for (int i = 0; i < NI_MAX; i++) wm[n][i] = W'($urandom());
    end
    for (int i = 0; i < NI_MAX; i++) am[i] = W'($urandom());
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int n = 0; n < N_OUT; n++) begin
      maskm[n] = '1;
      bm[n]    = '0;
      for (int i = 0; i < NI_MAX; i++) wm[n][i] = 14'sd1;
    end
    for (int i = 0; i < NI_MAX; i++) am[i] = 14'sd1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < NDUT; g++) begin
      check_val("rst_busy", busy[g], 0);
      check_val("rst_done", done[g], 0);
      check_val("rst_rd_en", rd_en[g], 0);
      check_val("rst_wr_en", wr_en[g], 0);
      check_val("rst_wr_data", wr_data[g], 0);
      check_val("rst_rd_chunk", rd_chunk[g], 0);
    end
    rst = 1'b0;

    // Dense all-ones layer: config 0 writes 12 per neuron, 6 cycles each.
    run_pass(-1);

    // Boundary neurons: skipped chunks, bias-only, rounding edges, saturation both ways.
    randomize_layer();
    am[0] = 14'sd32;
    am[1] = 14'sd1;
    am[2] = 14'sd0;
    for (int i = 3; i < NI_MAX; i++) am[i] = 14'sd8191;
    maskm[0] = 4'b1010;
    maskm[1] = 4'b0000; bm[1] = 14'sd5;
    maskm[2] = 4'b0000; bm[2] = -14'sd5;
    maskm[3] = 4'b0001; bm[3] = '0; wm[3][0] = 14'sd32;  wm[3][1] = 14'sd0;
    maskm[4] = 4'b0001; bm[4] = '0; wm[4][0] = 14'sd31;  wm[4][1] = 14'sd31;
    maskm[5] = 4'b0001; bm[5] = '0; wm[5][0] = -14'sd32; wm[5][1] = -14'sd1;
    maskm[6] = 4'b1111; bm[6] = 14'sd8191;
    maskm[7] = 4'b1111; bm[7] = -14'sd8192;
    for (int i = 0; i < NI_MAX; i++) begin
      wm[6][i] = 14'sd8191;
      wm[7][i] = -14'sd8192;
    end
    run_pass(-1);

    // Reset during neuron 5's issue phase, then a clean pass on the same layer.
    randomize_layer();
    maskm[5] = 4'b1111;
    run_pass(5);
    run_pass(-1);

    for (int k = 0; k < 4; k++) begin
      randomize_layer();
      run_pass(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
